// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the mmu CPU-side port between NUM_REQ requesters.
// Each transaction takes exactly three cycles: accept (IDLE), ACCESS, RESP.
module mem_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0][1:0]     req_unit,
  input  logic [NUM_REQ-1:0][31:0]    req_addr,
  input  logic [NUM_REQ-1:0][31:0]    req_wd,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_err,
  output logic [31:0]                 rsp_rd,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [1:0]                  mem_rd_unit,
  output logic [1:0]                  mem_wd_unit,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wd,
  input  logic [31:0]                 mem_rd,
  input  logic                        access_fault,
  input  logic                        addr_misaligned,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state, state_nxt;
  logic [GW-1:0]  last_grant, grant_q, winner;
  logic           found;
  logic           we_q, err_q;
  logic [1:0]     unit_q;
  logic [31:0]    addr_q, wd_q;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest at or
  // below it. Descending loops let the last (lowest) hit win.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && GW'(j) <= last_grant) begin
        found  = 1'b1;
        winner = GW'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && GW'(j) > last_grant) begin
        found  = 1'b1;
        winner = GW'(j);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GW'(NUM_REQ - 1);
      grant_q    <= '0;
      we_q       <= 1'b0;
      unit_q     <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_q <= winner;
          we_q    <= req_we[winner];
          unit_q  <= req_unit[winner];
          addr_q  <= req_addr[winner];
          wd_q    <= req_wd[winner];
        end
        ACCESS:  err_q      <= access_fault | addr_misaligned;
        RESP:    last_grant <= grant_q;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_err     = 1'b0;
    rsp_rd      = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_rd_unit = '0;
    mem_wd_unit = '0;
    mem_addr    = '0;
    mem_wd      = '0;
    busy        = 1'b0;
    grant_id    = '0;
    // Outputs are forced quiet while reset is held, so an aborted RESP never shows.
    if (!reset) begin
      mem_rd_unit = unit_q;
      mem_wd_unit = unit_q;
      mem_addr    = addr_q;
      mem_wd      = wd_q;
      busy        = (state != IDLE);
      grant_id    = grant_q;
      case (state)
        IDLE: if (found) req_ready[winner] = 1'b1;
        ACCESS: begin
          mem_re = ~we_q;
          mem_we = we_q;
        end
        RESP: begin
          rsp_valid[grant_q] = 1'b1;
          rsp_err            = err_q;
          if (!we_q && !err_q) rsp_rd = mem_rd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-requester instance against a small mmu
// model (sync RAM/ROM, fault decode) and a 4-requester instance for wrap-around.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        req, req_ready, req_we, rsp_valid;
  logic [1:0][1:0]   req_unit;
  logic [1:0][31:0]  req_addr, req_wd;
  logic              rsp_err, mem_re, mem_we, access_fault, addr_misaligned, busy;
  logic [31:0]       rsp_rd, mem_addr, mem_wd, mem_rd;
  logic [1:0]        mem_rd_unit, mem_wd_unit;
  logic [0:0]        grant_id;

  logic [3:0]        req4, req_ready4, rsp_valid4;
  logic [3:0][1:0]   req_unit4;
  logic [3:0][31:0]  req_addr4, req_wd4;
  logic              rsp_err4, mem_re4, mem_we4, busy4;
  logic [31:0]       rsp_rd4, mem_addr4, mem_wd4;
  logic [1:0]        mem_rd_unit4, mem_wd_unit4, grant_id4;

  int vectors = 0;
  int miscompares = 0;
  int we_pulses = 0;

  mem_arbiter #(.NUM_REQ(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_ready(req_ready), .req_we(req_we),
    .req_unit(req_unit), .req_addr(req_addr), .req_wd(req_wd),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rd(rsp_rd),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rd_unit(mem_rd_unit),
    .mem_wd_unit(mem_wd_unit), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .access_fault(access_fault),
    .addr_misaligned(addr_misaligned), .busy(busy), .grant_id(grant_id)
  );

  mem_arbiter #(.NUM_REQ(4)) u_dut4 (
    .clk(clk), .reset(reset), .req(req4), .req_ready(req_ready4),
    .req_we(4'b0000), .req_unit(req_unit4), .req_addr(req_addr4),
    .req_wd(req_wd4), .rsp_valid(rsp_valid4), .rsp_err(rsp_err4),
    .rsp_rd(rsp_rd4), .mem_re(mem_re4), .mem_we(mem_we4),
    .mem_rd_unit(mem_rd_unit4), .mem_wd_unit(mem_wd_unit4),
    .mem_addr(mem_addr4), .mem_wd(mem_wd4), .mem_rd(32'h0),
    .access_fault(1'b0), .addr_misaligned(1'b0), .busy(busy4),
    .grant_id(grant_id4)
  );

  // mmu model: RAM 0x4000_0000..0x4001_FFFF, ROM at 0x8xxx_xxxx, unit 0/1/2 = byte/half/word
  logic [31:0] ram [0:32767];
  logic in_ram, in_rom;
  assign in_ram = (mem_addr[31:17] == 15'h2000);
  assign in_rom = (mem_addr[31:28] == 4'h8);

  always_comb begin
    access_fault    = (mem_re | mem_we) && (!(in_ram || in_rom) || (mem_we && in_rom));
    addr_misaligned = (mem_re | mem_we) &&
                      ((mem_rd_unit == 2'd2 && mem_addr[1:0] != 2'b00) ||
                       (mem_rd_unit == 2'd1 && mem_addr[0]));
  end

  always @(posedge clk) begin
    if (mem_we && !access_fault && !addr_misaligned && in_ram)
      ram[mem_addr[16:2]] <= mem_wd;
    if (mem_re)
      mem_rd <= in_ram ? ram[mem_addr[16:2]] : (in_rom ? 32'h0000_0013 : 32'hBADB_AD00);
    if (mem_we)
      we_pulses <= we_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 32'h0;
    ram[0] = 32'hCAFE_F00D;
    ram[4] = 32'hDEAD_BEEF;
    reset = 1'b1; req = '0; req_we = '0; req_unit = '0; req_addr = '0; req_wd = '0;
    req4 = '0; req_unit4 = '0; req_addr4 = '0; req_wd4 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    req = 2'b11;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_mem_re", mem_re, 0);

    // Single read by requester 0
    @(negedge clk);
    reset = 1'b0; req = 2'b01; req_addr[0] = 32'h4000_0010; req_unit[0] = 2'd2;
    #1;
    check("rd_ready", req_ready, 2'b01);
    check("rd_busy_accept", busy, 0);
    @(negedge clk); req = 2'b00; #1;
    check("rd_mem_re", mem_re, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 32'h4000_0010);
    check("rd_unit", mem_rd_unit, 2'd2);
    check("rd_busy", busy, 1);
    check("rd_grant", grant_id, 0);
    check("rd_no_ready", req_ready, 0);
    @(negedge clk); #1;
    check("rd_rsp_valid", rsp_valid, 2'b01);
    check("rd_rsp_rd", rsp_rd, 32'hDEAD_BEEF);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_resp_re", mem_re, 0);
    check("rd_resp_addr", mem_addr, 32'h4000_0010);
    @(negedge clk); #1;
    check("rd_idle_busy", busy, 0);
    check("rd_idle_valid", rsp_valid, 0);
    check("rd_idle_rd", rsp_rd, 0);

    // Requester 1 writes then reads back
    @(negedge clk);
    req = 2'b10; req_we[1] = 1'b1; req_addr[1] = 32'h4001_8000;
    req_wd[1] = 32'h1234_5678; req_unit[1] = 2'd2;
    #1;
    check("wr_ready", req_ready, 2'b10);
    @(negedge clk); req = 2'b00; #1;
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_re", mem_re, 0);
    check("wr_mem_wd", mem_wd, 32'h1234_5678);
    check("wr_grant", grant_id, 1);
    @(negedge clk); #1;
    check("wr_rsp_valid", rsp_valid, 2'b10);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rd", rsp_rd, 0);
    check("wr_resp_we", mem_we, 0);
    @(negedge clk); req = 2'b10; req_we[1] = 1'b0; #1;
    check("rb_ready", req_ready, 2'b10);
    check("wr_pulses", we_pulses, 1);
    @(negedge clk); req = 2'b00; #1;
    check("rb_mem_re", mem_re, 1);
    check("rb_mem_addr", mem_addr, 32'h4001_8000);
    @(negedge clk); #1;
    check("rb_rsp_valid", rsp_valid, 2'b10);
    check("rb_rsp_rd", rsp_rd, 32'h1234_5678);
    @(negedge clk); #1;
    check("rb_idle", busy, 0);

    // Write to ROM faults but still strobes mem_we
    @(negedge clk);
    req = 2'b01; req_we[0] = 1'b1; req_addr[0] = 32'h8000_0000; req_wd[0] = 32'hFFFF_FFFF;
    #1;
    check("rom_ready", req_ready, 2'b01);
    @(negedge clk); req = 2'b00; #1;
    check("rom_mem_we", mem_we, 1);
    @(negedge clk); #1;
    check("rom_rsp_valid", rsp_valid, 2'b01);
    check("rom_rsp_err", rsp_err, 1);

    // Misaligned word read: error and zero data
    @(negedge clk);
    req = 2'b10; req_addr[1] = 32'h4000_0001;
    #1;
    check("mis_ready", req_ready, 2'b10);
    @(negedge clk); req = 2'b00;
    @(negedge clk); #1;
    check("mis_rsp_valid", rsp_valid, 2'b10);
    check("mis_rsp_err", rsp_err, 1);
    check("mis_rsp_rd", rsp_rd, 0);

    // Unmapped read
    @(negedge clk);
    req = 2'b01; req_we[0] = 1'b0; req_addr[0] = 32'h0000_0000;
    #1;
    check("unm_ready", req_ready, 2'b01);
    @(negedge clk); req = 2'b00;
    @(negedge clk); #1;
    check("unm_rsp_valid", rsp_valid, 2'b01);
    check("unm_rsp_err", rsp_err, 1);
    check("unm_rsp_rd", rsp_rd, 0);
    @(negedge clk); #1;
    check("unm_idle_err", rsp_err, 0);

    // Reset in ACCESS aborts; first grant afterwards goes to requester 0
    @(negedge clk);
    req = 2'b11; req_addr[0] = 32'h4000_0010; req_addr[1] = 32'h4001_8000;
    #1;
    check("abort_ready", req_ready, 2'b10);
    @(negedge clk); reset = 1'b1; #1;
    check("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("abort_no_rsp", rsp_valid, 0);
    check("abort_idle", busy, 0);

    // Contention: alternate 0,1,0,1 with one accept every 3 cycles
    for (int t = 0; t < 4; t++) begin
      automatic int g = t % 2;
      check("cont_ready", req_ready, 32'(1 << g));
      @(negedge clk); #1;
      check("cont_grant", grant_id, g);
      check("cont_ready_access", req_ready, 0);
      @(negedge clk);
      if (t == 3) req = 2'b00;
      #1;
      check("cont_rsp_valid", rsp_valid, 32'(1 << g));
      check("cont_rsp_rd", rsp_rd, (g == 1) ? 32'h1234_5678 : 32'hDEAD_BEEF);
      check("cont_rsp_err", rsp_err, 0);
      @(negedge clk); #1;
    end
    check("cont_done", busy, 0);
    check("cont_done_ready", req_ready, 0);

    // NUM_REQ=4 wrap-around from last_grant=3 with req=0101
    req4 = 4'b0101;
    #1;
    check("wrap_ready0", req_ready4, 4'b0001);
    @(negedge clk); #1;
    check("wrap_grant0", grant_id4, 0);
    @(negedge clk); #1;
    check("wrap_rsp0", rsp_valid4, 4'b0001);
    @(negedge clk); #1;
    check("wrap_ready2", req_ready4, 4'b0100);
    @(negedge clk); req4 = 4'b0000; #1;
    check("wrap_grant2", grant_id4, 2);
    @(negedge clk); #1;
    check("wrap_rsp2", rsp_valid4, 4'b0100);
    @(negedge clk); #1;
    check("wrap_idle", busy4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
